vec_mem_xfer: RTL and testbench
===============================

Name: vec_mem_xfer

Overview:
- Moves one 64-bit vector register pair between data memory and the 4x32 vector register file.
- VLOAD: reads two consecutive 32-bit memory words, then does a single paired write into the register file (base index gets the low word, base+1 the high word).
- VSTORE: snapshots the register pair through the file's paired read port, then issues two 32-bit memory writes.
- Sits between the core's vector instruction issue logic and the data-memory port.

Parameters:
- ADDR_W, 32, memory byte-address width
- DATA_W, 32, vector element and memory word width; register pair is 2*DATA_W
- STRIDE, 4, byte offset between the low and high element in memory

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block idle and able to accept a command
- cmd_store  in  1  1 = VSTORE, 0 = VLOAD
- cmd_vreg  in  2  base vector register index
- cmd_addr  in  ADDR_W  memory byte address of the low element
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = write, 0 = read
- mem_req_addr  out  ADDR_W  request byte address
- mem_req_wdata  out  DATA_W  write data
- mem_rsp_valid  in  1  read data valid
- mem_rsp_rdata  in  DATA_W  read data
- vr_addr_r  out  2  register-file read base index
- vr_rdata_lo  in  DATA_W  register[base]
- vr_rdata_hi  in  DATA_W  register[base+1]
- vr_addr_w  out  2  register-file write base index
- vr_we  out  1  paired write enable, one cycle
- vr_wdata  out  2*DATA_W  {hi,lo} write data
- busy  out  1  not IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done: misaligned command, no side effects

Behaviour:
- Reset (async, any state): FSM to IDLE; mem_req_valid, vr_we, done, err, busy = 0; address, data and vreg latches cleared to 0; cmd_ready = 1 after reset release.
- cmd_ready = (state == IDLE). Accept on cmd_valid && cmd_ready. Latch store flag, vreg, addr.
- vr_addr_r: in IDLE it is combinationally cmd_vreg; otherwise the latched vreg. On a store accept, vr_rdata_lo/hi are snapshotted into a 2-word buffer at the accept edge.
- States: IDLE, LD_REQ0, LD_WAIT0, LD_REQ1, LD_WAIT1, LD_WB, ST_REQ0, ST_REQ1, FIN, ERR.
- Accept with cmd_addr[1:0] != 0 -> ERR. ERR pulses done=1, err=1 for one cycle, makes no memory or register access, then goes to IDLE.
- Load path:
  - LD_REQ0 issues a read at addr; on handshake -> LD_WAIT0.
  - On mem_rsp_valid, capture lo -> LD_REQ1, which reads addr+STRIDE -> LD_WAIT1; capture hi -> LD_WB.
  - LD_WB: vr_we=1, vr_addr_w=vreg, vr_wdata={hi,lo}, done=1 for this single cycle -> IDLE.
- Store path:
  - ST_REQ0 writes the lo buffer to addr; on handshake -> ST_REQ1, which writes the hi buffer to addr+STRIDE.
  - On handshake -> FIN. Writes are posted; no response is expected.
  - FIN: done=1 -> IDLE.
- Request rules:
  - While mem_req_valid && !mem_req_ready, the request holds valid, we, addr and wdata stable.
  - At most one request is outstanding at a time.
  - A response arrives no earlier than the cycle after the read handshake.
- mem_rsp_valid outside LD_WAIT0/LD_WAIT1 is ignored, including a stale response arriving after a reset mid-load.
- Address arithmetic is modulo 2^ADDR_W: addr 0xFFFF_FFFC gives a high address of 0x0000_0000.
- vreg=3 is legal. The pair partner index wraps to 0 inside the register file; this block only drives the base index.
- Minimum latency, accept cycle = T, ready always 1, response one cycle after request:
  - Load: done and vr_we at T+5; cmd_ready high again at T+6.
  - Store: done at T+3.
- A register write by other logic after a store is accepted does not affect the stored data, because of the snapshot.
- busy = !cmd_ready. done and vr_we are never asserted in the same cycle as mem_req_valid.

Decomposition:
- Shared package vec_pkg holds:
  - the state encoding (localparams, 4-bit)
  - VREG_IDX_W=2, VEC_PAIR_W=64
  - the misalignment mask constant
- No sub-module is needed. The 2-word assemble/snapshot buffer stays inline as one always block.

Test Plan:
- Reset, then VLOAD vreg=1 addr=0x100; memory holds [0x100]=0xAAAA0001, [0x104]=0xBBBB0002 -> single vr_we pulse at T+5 with vr_addr_w=1, vr_wdata=0xBBBB0002_AAAA0001; done coincident.
- VSTORE vreg=3 addr=0x200, file reads lo=0x11111111 hi=0x22222222 at accept; overwrite the file the next cycle -> writes 0x11111111@0x200 and 0x22222222@0x204; done at T+3.
- VLOAD with mem_req_ready low for 3 cycles per request and a 2-cycle response delay -> request fields held stable; exactly two reads; correct data written; no early done.
- cmd_addr=0x102 -> done=1 and err=1 one cycle after accept; zero mem_req_valid cycles; vr_we stays 0.
- Assert rst while in LD_WAIT1, then deliver the stale response after release -> outputs zero immediately, the response is ignored, vr_we never fires, cmd_ready=1.
- VLOAD at addr 0xFFFFFFFC -> second read address is 0x00000000.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared definitions for the vector memory transfer block: index widths,
// alignment mask and the transfer FSM state encoding.
package vec_pkg;

  localparam int VREG_IDX_W = 2;
  localparam int VEC_PAIR_W = 64;

  // Low address bits that must be zero for a word-aligned transfer.
  localparam logic [1:0] MISALIGN_MASK = 2'b11;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    LD_REQ0  = 4'd1,
    LD_WAIT0 = 4'd2,
    LD_REQ1  = 4'd3,
    LD_WAIT1 = 4'd4,
    LD_WB    = 4'd5,
    ST_REQ0  = 4'd6,
    ST_REQ1  = 4'd7,
    FIN      = 4'd8,
    ERR      = 4'd9
  } xferState_t;

endpackage

// File: rtl/vec_mem_xfer.sv
// Moves one 64-bit vector register pair between data memory and the 4x32
// vector register file: VLOAD reads two words then does one paired write,
// VSTORE snapshots the pair at accept and issues two posted word writes.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | ready for a command; read port follows cmd_vreg
// LD_REQ0  | read request for the low word at addr
// LD_WAIT0 | waiting for the low-word response
// LD_REQ1  | read request for the high word at addr+STRIDE
// LD_WAIT1 | waiting for the high-word response
// LD_WB    | single paired register write, done pulse
// ST_REQ0  | write request, low snapshot word to addr
// ST_REQ1  | write request, high snapshot word to addr+STRIDE
// FIN      | store complete, done pulse
// ERR      | misaligned command, done+err pulse, no side effects
module vec_mem_xfer
  import vec_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRIDE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_store,
  input  logic [VREG_IDX_W-1:0] cmd_vreg,
  input  logic [ADDR_W-1:0]     cmd_addr,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic [DATA_W-1:0]     mem_req_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_W-1:0]     mem_rsp_rdata,
  output logic [VREG_IDX_W-1:0] vr_addr_r,
  input  logic [DATA_W-1:0]     vr_rdata_lo,
  input  logic [DATA_W-1:0]     vr_rdata_hi,
  output logic [VREG_IDX_W-1:0] vr_addr_w,
  output logic                  vr_we,
  output logic [2*DATA_W-1:0]   vr_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  xferState_t state, stateNext;

  logic                  storeQ;
  logic [VREG_IDX_W-1:0] vregQ;
  logic [ADDR_W-1:0]     addrQ;
  logic [DATA_W-1:0]     bufLo, bufHi;

  logic accept, misaligned;
  logic [ADDR_W-1:0] addrHi;

  assign accept     = cmd_valid && (state == IDLE);
  assign misaligned = (cmd_addr[1:0] & MISALIGN_MASK) != 2'b00;
  // Wraps modulo 2^ADDR_W by construction.
  assign addrHi     = addrQ + ADDR_W'(STRIDE);

  assign busy      = !cmd_ready;
  assign vr_addr_w = vregQ;
  assign vr_wdata  = {bufHi, bufLo};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Command latch: direction, base register and low-element address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      storeQ <= 1'b0;
      vregQ  <= '0;
      addrQ  <= '0;
    end else if (accept) begin
      storeQ <= cmd_store;
      vregQ  <= cmd_vreg;
      addrQ  <= cmd_addr;
    end
  end

  // Pair buffer: snapshot of the register pair on store accept, or the
  // assembled memory words during a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bufLo <= '0;
      bufHi <= '0;
    end else if (accept && cmd_store && !misaligned) begin
      bufLo <= vr_rdata_lo;
      bufHi <= vr_rdata_hi;
    end else if (state == LD_WAIT0 && mem_rsp_valid) begin
      bufLo <= mem_rsp_rdata;
    end else if (state == LD_WAIT1 && mem_rsp_valid) begin
      bufHi <= mem_rsp_rdata;
    end
  end

  // Next-state and per-state outputs; request fields come only from latched
  // state so they stay stable while a request is stalled.
  always_comb begin
    stateNext     = state;
    cmd_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = addrQ;
    mem_req_wdata = '0;
    vr_addr_r     = vregQ;
    vr_we         = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        vr_addr_r = cmd_vreg;
        if (cmd_valid) begin
          if (misaligned)     stateNext = ERR;
          else if (cmd_store) stateNext = ST_REQ0;
          else                stateNext = LD_REQ0;
        end
      end
      LD_REQ0: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) stateNext = LD_WAIT0;
      end
      LD_WAIT0: if (mem_rsp_valid) stateNext = LD_REQ1;
      LD_REQ1: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = addrHi;
        if (mem_req_ready) stateNext = LD_WAIT1;
      end
      LD_WAIT1: if (mem_rsp_valid) stateNext = LD_WB;
      LD_WB: begin
        vr_we     = 1'b1;
        done      = 1'b1;
        stateNext = IDLE;
      end
      ST_REQ0: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_wdata = bufLo;
        if (mem_req_ready) stateNext = ST_REQ1;
      end
      ST_REQ1: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = addrHi;
        mem_req_wdata = bufHi;
        if (mem_req_ready) stateNext = FIN;
      end
      FIN: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      ERR: begin
        done      = 1'b1;
        err       = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vec_mem_xfer.sv
// Directed bench for vec_mem_xfer: a behavioural memory with configurable
// ready stalls and response delay, a 4x32 register file read model, and a
// cycle monitor. All expected values are hand-computed constants.
module tb_vec_mem_xfer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_store;
  logic [1:0]  cmd_vreg;
  logic [31:0] cmd_addr;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic [1:0]  vr_addr_r, vr_addr_w, hiIdx;
  logic [31:0] vr_rdata_lo, vr_rdata_hi;
  logic        vr_we;
  logic [63:0] vr_wdata;
  logic        busy, done, err;

  logic [31:0] rf [4];
  assign hiIdx       = vr_addr_r + 2'd1;
  assign vr_rdata_lo = rf[vr_addr_r];
  assign vr_rdata_hi = rf[hiIdx];

  int compared = 0;
  int mismatched = 0;

  int stallCfg = 0, rspDelayCfg = 1;
  int stallCnt = 0, rspCnt = 0;
  logic [31:0] rspData;
  int rdCount = 0, wrCount = 0, holdErr = 0, rspDelivered = 0;
  logic [31:0] rdAddr [32];
  logic [31:0] wrAddr [32];
  logic [31:0] wrData [32];
  logic        prevStall = 1'b0, prevWe;
  logic [31:0] prevAddr, prevWdata;

  int vrWeCount = 0, doneCount = 0, reqCycles = 0, overlapCount = 0;

  logic        dVrWe, dErr, dReq;
  logic [1:0]  dVrAddrW;
  logic [63:0] dWdata;

  vec_mem_xfer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
    .cmd_vreg(cmd_vreg), .cmd_addr(cmd_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .vr_addr_r(vr_addr_r), .vr_rdata_lo(vr_rdata_lo), .vr_rdata_hi(vr_rdata_hi),
    .vr_addr_w(vr_addr_w), .vr_we(vr_we), .vr_wdata(vr_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memRead(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'hAAAA0001;
      32'h0000_0104: return 32'hBBBB0002;
      32'hFFFF_FFFC: return 32'hCCCC0003;
      32'h0000_0000: return 32'hDDDD0004;
      32'h0000_0300: return 32'h33330005;
      32'h0000_0304: return 32'h44440006;
      default:       return 32'hDEADBEEF ^ a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model: decides ready and logs handshakes at the negedge before
  // the edge that completes them; a read response pulses rspDelayCfg cycles
  // later. Checks that a stalled request is held unchanged.
  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      if (rspCnt > 0) begin
        rspCnt--;
        if (rspCnt == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = rspData;
          rspDelivered++;
        end
      end
      if (prevStall && (!mem_req_valid || mem_req_addr !== prevAddr ||
                        mem_req_we !== prevWe || mem_req_wdata !== prevWdata))
        holdErr++;
      if (mem_req_valid) begin
        if (stallCnt < stallCfg) begin
          mem_req_ready = 1'b0;
          stallCnt++;
        end else begin
          mem_req_ready = 1'b1;
          stallCnt = 0;
          if (mem_req_we) begin
            wrAddr[wrCount] = mem_req_addr;
            wrData[wrCount] = mem_req_wdata;
            wrCount++;
          end else begin
            rdAddr[rdCount] = mem_req_addr;
            rdCount++;
            rspData = memRead(mem_req_addr);
            rspCnt = rspDelayCfg;
          end
        end
      end else begin
        mem_req_ready = (stallCfg == 0);
      end
      prevStall = mem_req_valid && !mem_req_ready;
      prevAddr  = mem_req_addr;
      prevWe    = mem_req_we;
      prevWdata = mem_req_wdata;
    end
  end

  // Cycle monitor for pulse counts and done/vr_we vs request overlap.
  initial begin
    forever begin
      @(negedge clk);
      if (vr_we) vrWeCount++;
      if (done) doneCount++;
      if (mem_req_valid) reqCycles++;
      if ((done || vr_we) && mem_req_valid) overlapCount++;
    end
  end

  // Offer one command at a negedge and count cycles until done (bounded).
  task automatic runCmd(input logic st, input logic [1:0] vreg, input logic [31:0] addr,
                        input bit overwrite, output int lat);
    cmd_valid = 1'b1;
    cmd_store = st;
    cmd_vreg  = vreg;
    cmd_addr  = addr;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        cmd_valid = 1'b0;
        if (overwrite) begin
          rf[3] = 32'h5A5A5A5A;
          rf[0] = 32'hA5A5A5A5;
        end
      end
    end while (!done && lat < 40);
    dVrWe    = vr_we;
    dVrAddrW = vr_addr_w;
    dWdata   = vr_wdata;
    dErr     = err;
    dReq     = mem_req_valid;
  endtask

  initial begin
    int lat, rdB, wrB, weB, dnB, rqB, hdB, rsB, waitCyc;
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_store = 1'b0; cmd_vreg = '0; cmd_addr = '0;
    rf[0] = 32'h0; rf[1] = 32'h0; rf[2] = 32'h0; rf[3] = 32'h0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_vr_we", vr_we, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);

    // Basic VLOAD.
    rdB = rdCount; weB = vrWeCount;
    runCmd(1'b0, 2'd1, 32'h100, 1'b0, lat);
    chk("ld_latency", lat, 5);
    chk("ld_vr_we", dVrWe, 1);
    chk("ld_vr_addr_w", dVrAddrW, 1);
    chk("ld_vr_wdata", dWdata, 64'hBBBB0002_AAAA0001);
    chk("ld_err", dErr, 0);
    chk("ld_reads", rdCount - rdB, 2);
    chk("ld_rd_addr0", rdAddr[rdB], 32'h100);
    chk("ld_rd_addr1", rdAddr[rdB+1], 32'h104);
    @(negedge clk);
    chk("ld_ready_again", cmd_ready, 1);
    chk("ld_vr_we_pulses", vrWeCount - weB, 1);

    // VSTORE from vreg 3 (partner wraps to 0), file overwritten after accept.
    rf[3] = 32'h11111111;
    rf[0] = 32'h22222222;
    wrB = wrCount; weB = vrWeCount;
    runCmd(1'b1, 2'd3, 32'h200, 1'b1, lat);
    chk("st_latency", lat, 3);
    chk("st_err", dErr, 0);
    chk("st_vr_we", dVrWe, 0);
    chk("st_writes", wrCount - wrB, 2);
    chk("st_wr_addr0", wrAddr[wrB], 32'h200);
    chk("st_wr_data0", wrData[wrB], 32'h11111111);
    chk("st_wr_addr1", wrAddr[wrB+1], 32'h204);
    chk("st_wr_data1", wrData[wrB+1], 32'h22222222);
    @(negedge clk);
    chk("st_no_reg_write", vrWeCount - weB, 0);

    // VLOAD with 3 stall cycles per request and 2-cycle response delay.
    stallCfg = 3; rspDelayCfg = 2;
    rdB = rdCount; weB = vrWeCount; hdB = holdErr;
    runCmd(1'b0, 2'd2, 32'h300, 1'b0, lat);
    chk("stall_latency", lat, 13);
    chk("stall_vr_wdata", dWdata, 64'h44440006_33330005);
    chk("stall_vr_addr_w", dVrAddrW, 2);
    chk("stall_reads", rdCount - rdB, 2);
    chk("stall_rd_addr1", rdAddr[rdB+1], 32'h304);
    chk("stall_hold", holdErr - hdB, 0);
    stallCfg = 0; rspDelayCfg = 1;
    @(negedge clk);
    chk("stall_vr_we_pulses", vrWeCount - weB, 1);

    // Misaligned command.
    rdB = rdCount; wrB = wrCount; weB = vrWeCount; rqB = reqCycles;
    runCmd(1'b0, 2'd0, 32'h102, 1'b0, lat);
    chk("mis_latency", lat, 1);
    chk("mis_err", dErr, 1);
    chk("mis_vr_we", dVrWe, 0);
    @(negedge clk);
    chk("mis_err_pulse", err, 0);
    chk("mis_req_cycles", reqCycles - rqB, 0);
    chk("mis_mem_access", (rdCount - rdB) + (wrCount - wrB), 0);
    chk("mis_vr_we_pulses", vrWeCount - weB, 0);
    chk("mis_ready", cmd_ready, 1);

    // Reset during LD_WAIT1, stale response delivered after release.
    rspDelayCfg = 6;
    rdB = rdCount; weB = vrWeCount; dnB = doneCount; rsB = rspDelivered;
    cmd_valid = 1'b1; cmd_store = 1'b0; cmd_vreg = 2'd2; cmd_addr = 32'h100;
    @(negedge clk);
    cmd_valid = 1'b0;
    waitCyc = 0;
    while ((rdCount - rdB) < 2 && waitCyc < 40) begin
      @(negedge clk);
      waitCyc++;
    end
    chk("rr_reads_before_rst", rdCount - rdB, 2);
    @(negedge clk);
    chk("rr_busy_before_rst", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("rr_busy", busy, 0);
    chk("rr_ready", cmd_ready, 1);
    chk("rr_done", done, 0);
    chk("rr_vr_we", vr_we, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("rr_stale_delivered", rspDelivered - rsB, 2);
    chk("rr_vr_we_pulses", vrWeCount - weB, 0);
    chk("rr_done_pulses", doneCount - dnB, 0);
    chk("rr_ready_after", cmd_ready, 1);
    rspDelayCfg = 1;

    // High-address wrap.
    rdB = rdCount;
    runCmd(1'b0, 2'd0, 32'hFFFF_FFFC, 1'b0, lat);
    chk("wrap_latency", lat, 5);
    chk("wrap_rd_addr0", rdAddr[rdB], 32'hFFFF_FFFC);
    chk("wrap_rd_addr1", rdAddr[rdB+1], 32'h0000_0000);
    chk("wrap_vr_wdata", dWdata, 64'hDDDD0004_CCCC0003);
    @(negedge clk);

    chk("no_done_req_overlap", overlapCount, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
